// File: rtl/house_pkg.sv
// house_pkg: shared types and constants for the house tile.
//   house_state_t        : INTACT -> DAMAGED -> FLASH -> DESTROYED
//   TRANSPARENT_ENCODING : colour value that means "no pixel"
//   BITMAP_W/H/ADDR_W    : 32x32 bitmap, 10-bit ROM address
//   FRAME_CNT_W          : width of the saturating frame counter
package house_pkg;

    localparam int BITMAP_W      = 32;
    localparam int BITMAP_H      = 32;
    localparam int BITMAP_ADDR_W = 10;
    localparam int FRAME_CNT_W   = 10;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef enum logic [1:0] {
        INTACT,
        DAMAGED,
        FLASH,
        DESTROYED
    } house_state_t;

endpackage

// File: rtl/house_bitmap_if.sv
// house_bitmap_if: pixel bus between the bracket stage and the house tile.
//   insideBracket   : upstream drawing request (pixel inside tile)
//   offsetX/offsetY : 11-bit offsets from tile top-left
//   drawingRequest  : house pixel is opaque and visible (registered)
//   RGBout          : pixel colour, TRANSPARENT_ENCODING when not drawing
// master = upstream/bench side, slave = house tile.
interface house_bitmap_if;

    logic        insideBracket;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        drawingRequest;
    logic [7:0]  RGBout;

    modport master (
        output insideBracket, offsetX, offsetY,
        input  drawingRequest, RGBout
    );

    modport slave (
        input  insideBracket, offsetX, offsetY,
        output drawingRequest, RGBout
    );

endinterface

// File: rtl/house_bitmap_rom.sv
// house_bitmap_rom: 2 banks x 1024 x 8-bit house bitmap, combinational read.
//   bank : 0 = intact art, 1 = damaged art
//   addr : {y[4:0], x[4:0]}
//   pix  : colour, TRANSPARENT_ENCODING where the house is see-through
// The art is generated from the coordinates: the rightmost 4 columns are
// transparent in both banks, and the damaged bank adds diagonal cracks.
module house_bitmap_rom
    import house_pkg::*;
(
    input  logic                     bank,
    input  logic [BITMAP_ADDR_W-1:0] addr,
    output logic [7:0]               pix
);

    localparam int XW = $clog2(BITMAP_W);
    localparam int YW = $clog2(BITMAP_H);

    logic [XW-1:0] x;
    logic [YW-1:0] y;

    assign x = addr[XW-1:0];
    assign y = addr[XW+YW-1:XW];

    always_comb begin
        pix = TRANSPARENT_ENCODING;
        if (x < XW'(BITMAP_W - 4)) begin
            if (!bank) begin
                pix = 8'h1C ^ {y, 3'b000};
            end else if (x[1:0] != y[1:0]) begin
                pix = 8'hA0 ^ {3'b000, x};
            end
        end
    end

endmodule

// File: rtl/house_bitmap_fsm.sv
// house_bitmap_fsm: house tile bitmap lookup plus damage state machine.
//   clk, resetN      : pixel clock, asynchronous active-low reset
//   pix_bus (slave)  : insideBracket/offsets in, drawingRequest/RGBout out
//   collision        : single-cycle hit pulse
//   startOfFrame     : single-cycle pulse at the first pixel of a frame
//   hitCount         : saturating count of accepted hits
//   destroyed        : high in DESTROYED
// Optional macro HOUSE_REGEN_EN: DESTROYED returns to INTACT after
// REGEN_FRAMES frames; without it DESTROYED holds until resetN.
module house_bitmap_fsm
    import house_pkg::*;
#(
    parameter int MAX_HITS     = 3,
    parameter int DAMAGE_HITS  = 2,
    parameter int FLASH_FRAMES = 60,
    parameter int BLINK_PERIOD = 8,
    parameter int REGEN_FRAMES = 600
) (
    input  logic                 clk,
    input  logic                 resetN,
    house_bitmap_if.slave        pix_bus,
    input  logic                 collision,
    input  logic                 startOfFrame,
    output logic [2:0]           hitCount,
    output logic                 destroyed
);

    localparam int XW = $clog2(BITMAP_W);
    localparam int YW = $clog2(BITMAP_H);

    localparam logic [2:0] MAX_HC = 3'(MAX_HITS);
    localparam logic [2:0] DMG_HC = 3'(DAMAGE_HITS);
    localparam logic [FRAME_CNT_W-1:0] FLASH_LIM  = FRAME_CNT_W'(FLASH_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] BLINK_MASK = FRAME_CNT_W'(BLINK_PERIOD - 1);
`ifdef HOUSE_REGEN_EN
    localparam logic [FRAME_CNT_W-1:0] REGEN_LIM  = FRAME_CNT_W'(REGEN_FRAMES);
`endif

    if (MAX_HITS < 1 || MAX_HITS > 7) begin : g_bad_max_hits
        $error("MAX_HITS must be 1..7");
    end
    if (DAMAGE_HITS < 1 || DAMAGE_HITS >= MAX_HITS) begin : g_bad_damage_hits
        $error("DAMAGE_HITS must be 1..MAX_HITS-1");
    end
    if (FLASH_FRAMES > 1023 || REGEN_FRAMES > 1023 || BLINK_PERIOD > 1023) begin : g_bad_frames
        $error("frame parameters must fit the 10-bit frame counter");
    end
    if (BLINK_PERIOD < 1 || (BLINK_PERIOD & (BLINK_PERIOD - 1)) != 0) begin : g_bad_blink
        $error("BLINK_PERIOD must be a power of two");
    end

    house_state_t            state;
    logic [FRAME_CNT_W-1:0]  frame_cnt;
    logic [FRAME_CNT_W-1:0]  frame_nxt;
    logic                    blink_phase;
    logic                    hit_latch;

    logic [BITMAP_ADDR_W-1:0] addr;
    logic [7:0]               pix;
    logic                     bank;
    logic                     visible;
    logic                     draw;
    logic                     accept;
    logic                     unused_offset_bits;

    assign addr = {pix_bus.offsetY[YW-1:0], pix_bus.offsetX[XW-1:0]};
    assign unused_offset_bits = &{1'b0, pix_bus.offsetX[10:XW], pix_bus.offsetY[10:YW]};
    assign bank = (hitCount >= DMG_HC);

    house_bitmap_rom u_rom (
        .bank (bank),
        .addr (addr),
        .pix  (pix)
    );

    always_comb begin
        visible = 1'b0;
        case (state)
            INTACT, DAMAGED: visible = 1'b1;
            FLASH:           visible = ~blink_phase;
            default:         visible = 1'b0;
        endcase
    end

    // startOfFrame reopens the latch in the same cycle, so a collision
    // coinciding with it is counted for the new frame.
    assign accept    = collision && (state == INTACT || state == DAMAGED)
                       && (!hit_latch || startOfFrame);
    assign draw      = pix_bus.insideBracket && visible && (pix != TRANSPARENT_ENCODING);
    assign frame_nxt = (frame_cnt == '1) ? frame_cnt : frame_cnt + FRAME_CNT_W'(1);

    // State decisions read the registered hitCount, so a transition lands
    // one cycle after the hit that caused it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state                  <= INTACT;
            hitCount               <= '0;
            hit_latch              <= 1'b0;
            frame_cnt              <= '0;
            blink_phase            <= 1'b0;
            destroyed              <= 1'b0;
            pix_bus.drawingRequest <= 1'b0;
            pix_bus.RGBout         <= TRANSPARENT_ENCODING;
        end else begin
            pix_bus.drawingRequest <= draw;
            pix_bus.RGBout         <= draw ? pix : TRANSPARENT_ENCODING;

            if (accept) begin
                hit_latch <= 1'b1;
                if (hitCount < MAX_HC) hitCount <= hitCount + 3'd1;
            end else if (startOfFrame) begin
                hit_latch <= 1'b0;
            end

            case (state)
                INTACT, DAMAGED: begin
                    if (hitCount >= MAX_HC) begin
                        state       <= FLASH;
                        frame_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end else if (state == INTACT && hitCount >= DMG_HC) begin
                        state <= DAMAGED;
                    end
                end
                FLASH: begin
                    if (startOfFrame) begin
                        if (frame_nxt >= FLASH_LIM) begin
                            state     <= DESTROYED;
                            destroyed <= 1'b1;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_nxt;
                            if ((frame_nxt & BLINK_MASK) == '0) blink_phase <= ~blink_phase;
                        end
                    end
                end
                DESTROYED: begin
`ifdef HOUSE_REGEN_EN
                    if (startOfFrame) begin
                        if (frame_nxt >= REGEN_LIM) begin
                            state     <= INTACT;
                            destroyed <= 1'b0;
                            hitCount  <= '0;
                            hit_latch <= 1'b0;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_nxt;
                        end
                    end
`else
                    state <= DESTROYED;
`endif
                end
                default: state <= INTACT;
            endcase
        end
    end

endmodule

// File: doc/house_bitmap_fsm.md
Name: house_bitmap_fsm

Overview:
- Downstream consumer of the fixed-tile bracket stage for the house tile.
- Takes the in-bracket request and the 11-bit offsets, looks up a 32x32 8-bit bitmap, and outputs a registered drawing request and colour to the frame object mux.
- Tracks collision hits per frame and sequences the house through intact, damaged, flashing and destroyed states.
- Exports a destroyed flag to game logic.

Parameters:
MAX_HITS, 3, number of counted hits that ends the house (1..7)
DAMAGE_HITS, 2, hit count at which the damaged bitmap is selected (1..MAX_HITS-1)
FLASH_FRAMES, 60, frames spent in FLASH before DESTROYED
BLINK_PERIOD, 8, frames per visibility toggle while in FLASH (power of two)
REGEN_FRAMES, 600, frames in DESTROYED before regeneration (used only with the optional feature)

Ports:
clk  in  1  pixel clock
resetN  in  1  reset, asynchronous, active-low
insideBracket  in  1  upstream drawing request (pixel inside tile)
offsetX  in  11  upstream X offset from tile top-left
offsetY  in  11  upstream Y offset from tile top-left
collision  in  1  single-cycle pulse: projectile/tank overlaps house this pixel
startOfFrame  in  1  single-cycle pulse at the first pixel of each frame
drawingRequest  out  1  house pixel is opaque and visible
RGBout  out  8  pixel colour; 8'hFF when not drawing
hitCount  out  3  saturating count of accepted hits
destroyed  out  1  high in DESTROYED state

Behaviour:
- Reset (async, all outputs and state):
  - state=INTACT, hitCount=0, drawingRequest=0, RGBout=8'hFF, destroyed=0.
  - Frame counter, blink counter and the per-frame hit latch are cleared.
- Pixel path (1-cycle latency from inputs to outputs):
  - Address = {offsetY[4:0], offsetX[4:0]}; bits [10:5] are ignored.
  - ROM bank selection: bank 0 (intact) when hitCount<DAMAGE_HITS, bank 1 (damaged) otherwise.
  - pix = ROM[bank][addr].
  - drawingRequest <= insideBracket && visible && (pix != 8'hFF).
  - RGBout <= the same condition ? pix : 8'hFF.
  - visible = 1 in INTACT/DAMAGED; = ~blinkPhase in FLASH; = 0 in DESTROYED.
- Hit acceptance:
  - A collision is accepted only in INTACT or DAMAGED, and only if hitLatch=0.
  - On acceptance: hitCount+1 (saturating at MAX_HITS) and hitLatch is set.
  - startOfFrame clears hitLatch. If startOfFrame and collision arrive in the same cycle, the clear takes precedence and the collision is accepted, so at most one hit is counted per frame.
- State machine (transitions evaluated on the cycle after a hit is accepted, or on startOfFrame):
  - INTACT -> DAMAGED when hitCount reaches DAMAGE_HITS.
  - DAMAGED -> FLASH when hitCount reaches MAX_HITS. Frame counter is cleared and blinkPhase=0.
  - FLASH:
    - On each startOfFrame the frame counter increments.
    - blinkPhase toggles every BLINK_PERIOD frames.
    - After FLASH_FRAMES frames: go to DESTROYED and clear the frame counter.
    - Collisions are ignored.
  - DESTROYED:
    - destroyed=1, nothing is drawn, collisions are ignored.
    - Terminal state unless HOUSE_REGEN_EN is defined.
  - If DAMAGE_HITS-hit and MAX_HITS-hit conditions could be crossed together (not possible with a single hit per frame), go straight to FLASH.
- Widths:
  - Frame counter is 10 bits, saturating. A parameter value over 1023 is an elaboration error.
  - hitCount never exceeds MAX_HITS.
- The state change takes effect on the pixel path from the next clock edge, including mid-frame; no frame-alignment of bitmap swaps.

Optional Feature:
- Macro HOUSE_REGEN_EN.
- Defined:
  - DESTROYED counts startOfFrame pulses.
  - After REGEN_FRAMES frames: return to INTACT, clear hitCount and hitLatch, destroyed deasserts in the same cycle as the state change.
- Undefined:
  - DESTROYED is held until resetN.
  - REGEN_FRAMES is unused; no regen counter logic is synthesized.

Decomposition:
- Package house_pkg:
  - enum house_state_t {INTACT, DAMAGED, FLASH, DESTROYED}.
  - TRANSPARENT_ENCODING=8'hFF.
  - BITMAP_W=32, BITMAP_H=32, BITMAP_ADDR_W=10.
- Sub-module house_bitmap_rom:
  - 2 banks x 1024 x 8 bits.
  - Inputs: bank and addr. Output: pix.
  - Combinational read; the registered output stage stays in the parent.

Test Plan:
- Reset then insideBracket=1, offset (0,0) with ROM[0][0]=8'h1C -> next cycle drawingRequest=1, RGBout=8'h1C. With insideBracket=0 -> drawingRequest=0, RGBout=8'hFF.
- Pixel whose ROM entry is 8'hFF, inside bracket -> drawingRequest=0, RGBout=8'hFF. Offsets X=37 and X=5 return the same pixel.
- Three collision pulses within one frame -> hitCount=1 only. One pulse per frame over 2 frames -> hitCount=2, state DAMAGED, bank-1 pixels appear.
- startOfFrame and collision in the same cycle after a prior hit that frame -> the hit is accepted and hitCount increments.
- Third hit -> FLASH: drawingRequest toggles off/on every 8 frames. Collisions have no effect. After 60 frames destroyed=1 and drawingRequest stays 0.
- With HOUSE_REGEN_EN: after 600 frames in DESTROYED -> state INTACT, hitCount=0, destroyed=0. Without it: destroyed stays 1 for 2000 frames. resetN asserted mid-FLASH -> immediate INTACT, hitCount=0.
